// File: rtl/adder_64x1.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder_64x1 : registered 64-bit ripple-carry adder with signed overflow flag
// Revision   : 1.0
// ----------------------------------------------------------------------------

module adder_64x1_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module adder_64x1 (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum,
  output logic        overflow
);
  localparam int c_width = 64;

  logic [c_width:0]   w_c;
  logic [c_width-1:0] w_s;
  logic               w_ov;
  logic [c_width-1:0] r_sum;
  logic               r_overflow;

  assign w_c[0] = 1'b0;

  generate
    for (genvar i = 0; i < c_width; i++) begin : g_cell
      adder_64x1_fa u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (w_c[i]),
        .s  (w_s[i]),
        .co (w_c[i+1])
      );
    end
  endgenerate

  // Carry into and out of the sign bit disagree exactly on signed overflow.
  assign w_ov = w_c[c_width] ^ w_c[c_width-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_sum      <= w_s;
      r_overflow <= w_ov;
    end
  end

  assign sum      = r_sum;
  assign overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_adder_64x1.sv
`default_nettype none
// Self-checking bench for adder_64x1 against a 65-bit arithmetic reference.
module tb_adder_64x1;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a, b, sum;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_sum;
  logic        exp_ov;
  bit          have_exp = 0;
  logic [63:0] bnd [5];

  always #5 clk = ~clk;

  adder_64x1 dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sum      (sum),
    .overflow (overflow)
  );

  function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y);
    logic signed [64:0] t;
    t = $signed({x[63], x}) + $signed({y[63], y});
    return {t[64] != t[63], t[63:0]};
  endfunction

  task automatic check(input string tag);
    n_tests++;
    assert (sum === exp_sum) else begin
      n_fail++;
      $error("FAIL %s sum observed=%h expected=%h", tag, sum, exp_sum);
    end
    n_tests++;
    assert (overflow === exp_ov) else begin
      n_fail++;
      $error("FAIL %s overflow observed=%b expected=%b", tag, overflow, exp_ov);
    end
  endtask

  task automatic step(input logic r, input logic [63:0] x, input logic [63:0] y, input string tag);
    logic [64:0] m;
    @(negedge clk);
    if (have_exp) check({tag, "_hold"});
    rst = r;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    #2;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    if (r) begin
      exp_sum = '0;
      exp_ov  = 1'b0;
    end else begin
      m = ref_add(x, y);
      exp_sum = m[63:0];
      exp_ov  = m[64];
    end
    have_exp = 1;
    check(tag);
  endtask

  function automatic logic [63:0] pick();
    if ($urandom_range(0, 3) == 0) return bnd[$urandom_range(0, 4)];
    return {$urandom, $urandom};
  endfunction

  initial begin
    bnd[0] = 64'h0;
    bnd[1] = 64'h1;
    bnd[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    bnd[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    bnd[4] = 64'h8000_0000_0000_0000;
    rst = 1'b1;
    a = '0;
    b = '0;

    step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, "reset0");
    step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, "reset1");
    step(1'b0, 64'd0, 64'd0, "zero");

    step(1'b0, 64'd2, -64'd13, "mix_2_m13");
    step(1'b0, 64'd1092835, -64'd1020, "mix_big");
    step(1'b0, 64'd23, 64'd0, "mix_23_0");
    step(1'b0, 64'd9, -64'd9, "mix_9_m9");

    step(1'b0, 64'd1134, 64'd8238, "same_pos");
    step(1'b0, -64'd7478, -64'd46474, "same_neg");
    step(1'b0, -64'd2, -64'd13, "same_m2_m13");
    step(1'b0, 64'd7890678653, 64'd4238598110567, "same_large");
    step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "carry_out");

    step(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "ovf_pos");
    step(1'b0, 64'h8000_0000_0000_0000, -64'd1, "ovf_neg");
    step(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "ovf_min_min");
    step(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, "max_plus_min");

    for (int i = 0; i < 8; i++) step(1'b0, pick(), pick(), "pipe");
    step(1'b1, 64'd1134, 64'd8238, "reset_mid");
    step(1'b0, pick(), pick(), "post_reset");
    for (int i = 0; i < 4; i++) step(1'b0, pick(), pick(), "pipe2");

    for (int i = 0; i < 10000; i++) step(1'b0, pick(), pick(), "random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
